// File: rtl/disp_pkg.sv
// Shared types and helpers for the 4-digit seven-segment scan controller.
// Digit 0 is the rightmost digit and maps to an[0].
package disp_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

  typedef logic [1:0] digit_idx_t;

  localparam logic [3:0] AN_OFF = 4'hF;

  function automatic logic [3:0] an_onehot_n(
    input digit_idx_t d
  );
    logic [3:0] one;
    one = 4'b0001 << d;
    return ~one;
  endfunction

  function automatic logic [3:0] nibble_of(
    input logic [15:0] v,
    input digit_idx_t  d
  );
    return v[4*d +: 4];
  endfunction

  // A digit is a leading zero when it and every digit left of it are 0.
  function automatic logic lz_blank(
    input logic [15:0] v,
    input digit_idx_t  d
  );
    logic hit;
    hit = 1'b0;
    unique case (d)
      2'd3:    hit = (v[15:12] == 4'h0);
      2'd2:    hit = (v[15:8] == 8'h00);
      2'd1:    hit = (v[15:4] == 12'h000);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Per-digit slot timer: strobes the last cycle of the blanking window
// and the last cycle of the slot, so the FSM can switch on that edge.
module slot_timer #(
  parameter int SLOT_CYC  = 100_000,
  parameter int BLANK_CYC = 1_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic slot_start,
  output logic show_start
);

  localparam int W = $clog2(SLOT_CYC);
  localparam logic [W-1:0] LAST    = W'(SLOT_CYC - 1);
  localparam logic [W-1:0] SHOW_AT = W'(BLANK_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The next edge begins a new slot / the lit part of this slot.
  assign slot_start = run && (cnt == LAST);
  assign show_start = run && (cnt == SHOW_AT);

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan controller: cycles the four digits with a dark gap per slot, and
// swaps in newly loaded values only at the start of a frame.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SLOT_CYC  = 100_000,
  parameter int BLANK_CYC = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        load_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        lz_en_i,
  output logic [3:0]  nibble_o,
  output logic [1:0]  digit_o,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_o
);

  scan_state_t state;
  digit_idx_t  digit;
  logic [15:0] pending;
  logic [3:0]  pend_dp;
  logic [15:0] active;
  logic [3:0]  act_dp;

  logic run;
  logic slot_start;
  logic show_start;
  logic frame_edge;
  logic lit;

  assign run = enable_i && (state != ST_IDLE);

  slot_timer #(
    .SLOT_CYC  (SLOT_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .slot_start (slot_start),
    .show_start (show_start)
  );

  // True on the edge that opens a digit-0 slot.
  always_comb begin
    frame_edge = 1'b0;
    if (enable_i) begin
      unique case (state)
        ST_IDLE: frame_edge = 1'b1;
        ST_SHOW: frame_edge = slot_start &&
          (digit == digit_idx_t'(NUM_DIGITS - 1));
        default: frame_edge = 1'b0;
      endcase
    end
  end

  assign lit = enable_i && (state == ST_SHOW) &&
    !(lz_en_i && lz_blank(active, digit));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      digit    <= '0;
      pending  <= '0;
      pend_dp  <= '0;
      active   <= '0;
      act_dp   <= '0;
      an       <= AN_OFF;
      dp       <= 1'b1;
      nibble_o <= '0;
      digit_o  <= '0;
      frame_o  <= 1'b0;
    end else begin
      frame_o <= frame_edge;

      if (load_i) begin
        pending <= value_i;
        pend_dp <= dp_i;
      end

      // A load on the frame edge goes straight to the display.
      if (frame_edge) begin
        active <= load_i ? value_i : pending;
        act_dp <= load_i ? dp_i : pend_dp;
      end

      if (!enable_i) begin
        state <= ST_IDLE;
        digit <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            state <= ST_BLANK;
            digit <= '0;
          end
          ST_BLANK: begin
            if (show_start) state <= ST_SHOW;
          end
          ST_SHOW: begin
            if (slot_start) begin
              state <= ST_BLANK;
              digit <= digit + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            digit <= '0;
          end
        endcase
      end

      an       <= lit ? an_onehot_n(digit) : AN_OFF;
      dp       <= lit ? ~act_dp[digit] : 1'b1;
      nibble_o <= nibble_of(active, digit);
      digit_o  <= digit;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SLOT_CYC=8, BLANK_CYC=2.
// Views are taken 1 time unit after each rising edge.
module tb_display_scan_ctrl;
  import disp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b1;
  logic        load_i = 1'b0;
  logic [15:0] value_i = 16'h0;
  logic [3:0]  dp_i = 4'h0;
  logic        lz_en_i = 1'b0;
  logic [3:0]  nibble_o;
  logic [1:0]  digit_o;
  logic [3:0]  an;
  logic        dp;
  logic        frame_o;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;
  scan_state_t st_q;

  display_scan_ctrl #(
    .SLOT_CYC  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable_i),
    .load_i   (load_i),
    .value_i  (value_i),
    .dp_i     (dp_i),
    .lz_en_i  (lz_en_i),
    .nibble_o (nibble_o),
    .digit_o  (digit_o),
    .an       (an),
    .dp       (dp),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered on the view where the slot's BLANK state is first visible.
  task automatic slot(input int dg, input logic [3:0] an_e,
                      input logic [3:0] nib_e, input logic dp_e,
                      input logic fr_e, input int ld_at = 0,
                      input logic [15:0] ld_v = 16'h0,
                      input logic [3:0] ld_dp = 4'h0);
    chk($sformatf("frame d%0d", dg), 16'(frame_o), 16'(fr_e));
    for (int i = 1; i <= 8; i++) begin
      step();
      if (ld_at != 0 && i == ld_at + 1) load_i = 1'b0;
      if (i <= 2) begin
        chk($sformatf("blank_an d%0d", dg), 16'(an), 16'hF);
        chk($sformatf("blank_dp d%0d", dg), 16'(dp), 16'h1);
      end else begin
        chk($sformatf("an d%0d", dg), 16'(an), 16'(an_e));
        chk($sformatf("dp d%0d", dg), 16'(dp), 16'(dp_e));
      end
      chk($sformatf("nibble d%0d", dg), 16'(nibble_o), 16'(nib_e));
      chk($sformatf("digit d%0d", dg), 16'(digit_o), 16'(dg));
      if (i < 8) chk($sformatf("frame_lo d%0d", dg), 16'(frame_o), 16'h0);
      if (ld_at != 0 && i == ld_at) begin
        load_i  = 1'b1;
        value_i = ld_v;
        dp_i    = ld_dp;
      end
    end
  endtask

  always @(posedge clk) st_q <= dut.state;

  always @(negedge clk) begin
    if (mon_on && !rst) begin
      chk("one_anode", 16'($countones(~an) <= 1), 16'h1);
      if (st_q == ST_BLANK) chk("blank_dark", 16'(an), 16'hF);
    end
  end

  initial begin
    // 1: reset held with enable high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_dp", 16'(dp), 16'h1);
      chk("rst_nib", 16'(nibble_o), 16'h0);
      chk("rst_frame", 16'(frame_o), 16'h0);
    end
    mon_on   = 1'b1;
    rst      = 1'b0;
    enable_i = 1'b0;
    load_i   = 1'b1;
    value_i  = 16'h1234;
    dp_i     = 4'b0100;
    step();
    chk("idle_an", 16'(an), 16'hF);
    chk("idle_frame", 16'(frame_o), 16'h0);
    load_i   = 1'b0;
    enable_i = 1'b1;
    step();

    // 2: basic scan of 1234, then wrap
    slot(0, 4'hE, 4'h4, 1'b1, 1'b1);
    slot(1, 4'hD, 4'h3, 1'b1, 1'b0);
    slot(2, 4'hB, 4'h2, 1'b0, 1'b0);
    slot(3, 4'h7, 4'h1, 1'b1, 1'b0);
    slot(0, 4'hE, 4'h4, 1'b1, 1'b1);

    // 3: mid-frame load is held off; frame-edge load bypasses
    slot(1, 4'hD, 4'h3, 1'b1, 1'b0);
    slot(2, 4'hB, 4'h2, 1'b0, 1'b0, 4, 16'hABCD, 4'b0000);
    slot(3, 4'h7, 4'h1, 1'b1, 1'b0);
    slot(0, 4'hE, 4'hD, 1'b1, 1'b1);
    slot(1, 4'hD, 4'hC, 1'b1, 1'b0);
    slot(2, 4'hB, 4'hB, 1'b1, 1'b0);
    slot(3, 4'h7, 4'hA, 1'b1, 1'b0, 7, 16'h5678, 4'b0001);

    // 4: leading-zero suppression
    lz_en_i = 1'b1;
    slot(0, 4'hE, 4'h8, 1'b0, 1'b1, 4, 16'h0050, 4'b0000);
    slot(1, 4'hD, 4'h7, 1'b1, 1'b0);
    slot(2, 4'hB, 4'h6, 1'b1, 1'b0);
    slot(3, 4'h7, 4'h5, 1'b1, 1'b0);
    slot(0, 4'hE, 4'h0, 1'b1, 1'b1, 4, 16'h0000, 4'b0000);
    slot(1, 4'hD, 4'h5, 1'b1, 1'b0);
    slot(2, 4'hF, 4'h0, 1'b1, 1'b0);
    slot(3, 4'hF, 4'h0, 1'b1, 1'b0);
    slot(0, 4'hE, 4'h0, 1'b1, 1'b1);
    slot(1, 4'hF, 4'h0, 1'b1, 1'b0);
    slot(2, 4'hF, 4'h0, 1'b1, 1'b0);
    slot(3, 4'hF, 4'h0, 1'b1, 1'b0);

    // 5: disable mid-SHOW of digit 2, re-enable with a bypass load
    lz_en_i = 1'b0;
    slot(0, 4'hE, 4'h0, 1'b1, 1'b1);
    slot(1, 4'hD, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("d2_lit", 16'(an), 16'hB);
    enable_i = 1'b0;
    step();
    chk("off_an", 16'(an), 16'hF);
    chk("off_dp", 16'(dp), 16'h1);
    step();
    chk("off_an2", 16'(an), 16'hF);
    chk("off_digit", 16'(digit_o), 16'h0);
    chk("off_frame", 16'(frame_o), 16'h0);
    enable_i = 1'b1;
    load_i   = 1'b1;
    value_i  = 16'h00F7;
    dp_i     = 4'b0000;
    step();
    load_i = 1'b0;
    slot(0, 4'hE, 4'h7, 1'b1, 1'b1);

    // 6: reset mid-SHOW clears active value
    for (int i = 0; i < 4; i++) step();
    chk("d1_lit", 16'(an), 16'hD);
    chk("d1_nib", 16'(nibble_o), 16'hF);
    rst = 1'b1;
    step();
    chk("rst2_an", 16'(an), 16'hF);
    chk("rst2_dp", 16'(dp), 16'h1);
    chk("rst2_nib", 16'(nibble_o), 16'h0);
    chk("rst2_digit", 16'(digit_o), 16'h0);
    chk("rst2_frame", 16'(frame_o), 16'h0);
    rst = 1'b0;
    step();
    slot(0, 4'hE, 4'h0, 1'b1, 1'b1);
    slot(1, 4'hD, 4'h0, 1'b1, 1'b0);

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
